pipe_collision: RTL and testbench

Consumer of the bird's vertical position (y_coord) in the Flappy Bird datapath. Owns the single scrolling pipe: x position, pseudo-random gap height, bird-vs-pipe and bird-vs-ground collision, and the score counter. Feeds the renderer (pipe_x, gap_y) and the game FSM (collision, score).

---
 rtl/flappy_pkg.sv | 33 +++
 rtl/pipe_collision_lfsr16.sv | 20 ++
 rtl/pipe_collision.sv | 130 +++++++++++++
 tb/tb_pipe_collision.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared Flappy Bird constants: game states, geometry defaults,
// and the pipe-gap LFSR seed/taps with a one-step helper.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_TITLE = 2'd0,
    ST_READY = 2'd1,
    ST_PLAY  = 2'd2,
    ST_HOLD  = 2'd3
  } game_st_e;

  localparam int TICK_DIV_LOG2_D = 5;
  localparam int SCREEN_W_D      = 640;
  localparam int PIPE_W_D        = 60;
  localparam int PIPE_SPEED_D    = 2;
  localparam int BIRD_X_D        = 100;
  localparam int BIRD_W_D        = 20;
  localparam int BIRD_H_D        = 20;
  localparam int GAP_H_D         = 120;
  localparam int GAP_MIN_D       = 80;
  localparam int GAP_RESET_D     = 200;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 (1-based) -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_collision_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, seeded on reset.
// Ports: clk, rst (async high) in; rnd = low byte of state out.
module lfsr16
  import flappy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] rnd
);

  logic [15:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= LFSR_SEED;
    else     q <= lfsr_next(q);
  end

  assign rnd = q[7:0];

endmodule

// File: rtl/pipe_collision.sv
// Scrolling pipe, gap height, bird collision and score counter.
// In: clk, rst (async high), enable, state[1:0], y_coord (signed).
// Out: pipe_x (signed), gap_y, collision (sticky), score, score_pulse.
// Optional: FLAPPY_PIPE_SPEEDUP_EN adds +1 speed per 8 points (max +4).
module pipe_collision
  import flappy_pkg::*;
#(
  parameter int TICK_DIV_LOG2 = TICK_DIV_LOG2_D,
  parameter int SCREEN_W      = SCREEN_W_D,
  parameter int PIPE_W        = PIPE_W_D,
  parameter int PIPE_SPEED    = PIPE_SPEED_D,
  parameter int BIRD_X        = BIRD_X_D,
  parameter int BIRD_W        = BIRD_W_D,
  parameter int BIRD_H        = BIRD_H_D,
  parameter int GAP_H         = GAP_H_D,
  parameter int GAP_MIN       = GAP_MIN_D,
  parameter int GAP_RESET     = GAP_RESET_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [1:0]         state,
  input  logic signed [10:0] y_coord,
  output logic signed [10:0] pipe_x,
  output logic [10:0]        gap_y,
  output logic               collision,
  output logic [7:0]         score,
  output logic               score_pulse
);

  localparam logic signed [11:0] BX  = 12'(BIRD_X);
  localparam logic signed [11:0] BW  = 12'(BIRD_W);
  localparam logic signed [11:0] BH  = 12'(BIRD_H);
  localparam logic signed [11:0] PW  = 12'(PIPE_W);
  localparam logic signed [11:0] GH  = 12'(GAP_H);
  localparam logic signed [11:0] SPD = 12'(PIPE_SPEED);
  localparam logic signed [10:0] SPAWN_X = 11'(SCREEN_W);
  localparam logic [10:0] GAP_RST = 11'(GAP_RESET);
  localparam logic [10:0] GAP_LO  = 11'(GAP_MIN);

  logic [TICK_DIV_LOG2-1:0] div;
  logic                     tick;
  logic [7:0]               rnd;

  logic signed [11:0] px;
  logic signed [11:0] y;
  logic signed [11:0] gap;
  logic signed [11:0] spd;
  logic signed [11:0] nx;
  logic               overlap;
  logic               hit;
  logic               scored;
  logic               respawn;

  lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  assign tick = &div;

  // widen to 12 bits so x+W and y+H cannot wrap
  assign px  = {pipe_x[10], pipe_x};
  assign y   = {y_coord[10], y_coord};
  assign gap = {1'b0, gap_y};

`ifdef FLAPPY_PIPE_SPEEDUP_EN
  logic [4:0] bonus;
  assign bonus = (score[7:3] > 5'd4) ? 5'd4 : score[7:3];
  assign spd   = SPD + {7'd0, bonus};
`else
  assign spd = SPD;
`endif

  assign nx = px - spd;

  assign overlap = (BX + BW > px) && (BX < px + PW);

  assign hit = (overlap && ((y < gap) || (y + BH > gap + GH)))
             || (y <= 12'sd0);

  // pipe's right edge crosses the bird's left edge this tick
  assign scored = (px + PW >= BX) && (nx + PW < BX);

  assign respawn = (nx <= -PW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      pipe_x      <= SPAWN_X;
      gap_y       <= GAP_RST;
      collision   <= 1'b0;
      score       <= 8'd0;
      score_pulse <= 1'b0;
    end else begin
      div         <= div + 1'b1;
      score_pulse <= 1'b0;
      unique case (game_st_e'(state))
        ST_READY: begin
          pipe_x    <= SPAWN_X;
          gap_y     <= GAP_RST;
          collision <= 1'b0;
          score     <= 8'd0;
        end
        ST_PLAY: begin
          if (enable && tick && !collision) begin
            if (hit) begin
              collision <= 1'b1;
            end else begin
              if (scored && (score != 8'hFF)) begin
                score       <= score + 8'd1;
                score_pulse <= 1'b1;
              end
              if (respawn) begin
                pipe_x <= SPAWN_X;
                gap_y  <= GAP_LO + {3'd0, rnd};
              end else begin
                pipe_x <= nx[10:0];
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_collision.sv
// Self-checking bench for pipe_collision: table of play/ready/hold
// vectors plus hand sequences for latency, saturation, speed, reset.
module tb_pipe_collision;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b1;
  logic [1:0]         state = 2'd0;
  logic signed [10:0] y_coord = 11'sd250;
  logic signed [10:0] pipe_x;
  logic [10:0]        gap_y;
  logic               collision;
  logic [7:0]         score;
  logic               score_pulse;

  int nchecks = 0;
  int nerrors = 0;
  int npulse  = 0;

  logic [4:0] bdiv;

`ifdef FLAPPY_PIPE_SPEEDUP_EN
  localparam int STEP16 = 4;
`else
  localparam int STEP16 = 2;
`endif

  typedef struct {
    logic [1:0] st;
    logic       en;
    int         y;
    int         ticks;
    int         px;
    int         gap;
    bit         gap_rand;
    int         col;
    int         sc;
    int         pulses;
  } vec_t;

  localparam int NV = 17;
  vec_t v [NV];

  pipe_collision dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .state       (state),
    .y_coord     (y_coord),
    .pipe_x      (pipe_x),
    .gap_y       (gap_y),
    .collision   (collision),
    .score       (score),
    .score_pulse (score_pulse)
  );

  always #5 clk = ~clk;

  // tick phase reference: next posedge ticks when bdiv == 31
  always @(posedge clk or posedge rst) begin
    if (rst) bdiv <= '0;
    else     bdiv <= bdiv + 5'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      if (bdiv == 5'd31) k++;
      @(negedge clk);
      if (score_pulse) npulse++;
    end
  endtask

  task automatic pass_pipe(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      run_ticks(1);
      if (pipe_x == 11'sd640) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic preset_score(input logic [7:0] s);
    state = 2'd1;
    @(negedge clk);
    state = 2'd0;
    @(negedge clk);
    force dut.score = s;
    #1;
    release dut.score;
  endtask

  initial begin
    bit ok;
    int p0;

    //           st    en  y    tk   px   gap rnd col sc p
    v[0]  = '{2'd1, 1, 250,   1, 640, 200, 0, 0, 0, 0};
    v[1]  = '{2'd2, 1, 250, 301,  38, 200, 0, 0, 1, 1};
    v[2]  = '{2'd2, 1, 250,  49, 640,   0, 1, 0, 1, 0};
    v[3]  = '{2'd1, 1, 250,   1, 640, 200, 0, 0, 0, 0};
    v[4]  = '{2'd2, 1, 100, 261, 118, 200, 0, 0, 0, 0};
    v[5]  = '{2'd2, 1, 100,   1, 118, 200, 0, 1, 0, 0};
    v[6]  = '{2'd2, 1, 100,  20, 118, 200, 0, 1, 0, 0};
    v[7]  = '{2'd1, 1, 100,   1, 640, 200, 0, 0, 0, 0};
    v[8]  = '{2'd2, 1,   0,   1, 640, 200, 0, 1, 0, 0};
    v[9]  = '{2'd1, 1,   0,   1, 640, 200, 0, 0, 0, 0};
    v[10] = '{2'd2, 1, 250,   5, 630, 200, 0, 0, 0, 0};
    v[11] = '{2'd2, 0,   0,  16, 630, 200, 0, 0, 0, 0};
    v[12] = '{2'd3, 1,   0,   3, 630, 200, 0, 0, 0, 0};
    v[13] = '{2'd0, 1,   0,   3, 630, 200, 0, 0, 0, 0};
    v[14] = '{2'd1, 1, 301,   1, 640, 200, 0, 0, 0, 0};
    v[15] = '{2'd2, 1, 301, 261, 118, 200, 0, 0, 0, 0};
    v[16] = '{2'd2, 1, 301,   1, 118, 200, 0, 1, 0, 0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst pipe_x", int'(pipe_x), 640);
    chk("rst gap_y", int'(gap_y), 200);
    chk("rst collision", int'(collision), 0);
    chk("rst score", int'(score), 0);
    chk("rst pulse", int'(score_pulse), 0);

    // first tick lands on edge 2^N-1 after release
    state   = 2'd2;
    enable  = 1'b1;
    y_coord = 11'sd250;
    rst     = 1'b0;
    repeat (31) @(negedge clk);
    chk("pre-tick pipe_x", int'(pipe_x), 640);
    @(negedge clk);
    chk("first tick pipe_x", int'(pipe_x), 638);

    for (int i = 0; i < NV; i++) begin
      state   = v[i].st;
      enable  = v[i].en;
      y_coord = 11'(v[i].y);
      p0      = npulse;
      run_ticks(v[i].ticks);
      chk($sformatf("v%0d pipe_x", i), int'(pipe_x), v[i].px);
      if (v[i].gap_rand)
        chk($sformatf("v%0d gap range", i),
            int'(gap_y >= 11'd80 && gap_y <= 11'd335), 1);
      else
        chk($sformatf("v%0d gap_y", i), int'(gap_y), v[i].gap);
      chk($sformatf("v%0d collision", i), int'(collision), v[i].col);
      chk($sformatf("v%0d score", i), int'(score), v[i].sc);
      chk($sformatf("v%0d pulses", i), npulse - p0, v[i].pulses);
    end

    // 254 -> 255 still pulses
    preset_score(8'd254);
    state   = 2'd2;
    y_coord = 11'sd250;
    p0      = npulse;
    pass_pipe(ok);
    chk("sat254 respawn", int'(ok), 1);
    chk("sat254 score", int'(score), 255);
    chk("sat254 pulses", npulse - p0, 1);

    // saturated: no change, no pulse
    preset_score(8'd255);
    state = 2'd2;
    p0    = npulse;
    pass_pipe(ok);
    chk("sat255 respawn", int'(ok), 1);
    chk("sat255 score", int'(score), 255);
    chk("sat255 pulses", npulse - p0, 0);

    // speed at score 16
    preset_score(8'd16);
    state = 2'd2;
    run_ticks(1);
    chk("spd16 step1", int'(pipe_x), 640 - STEP16);
    run_ticks(1);
    chk("spd16 step2", int'(pipe_x), 640 - 2 * STEP16);
    chk("spd16 score", int'(score), 16);

    // async reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("async pipe_x", int'(pipe_x), 640);
    chk("async gap_y", int'(gap_y), 200);
    chk("async collision", int'(collision), 0);
    chk("async score", int'(score), 0);
    chk("async pulse", int'(score_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
